main_memory_responder: RTL and testbench
========================================

Name: main_memory_responder

Overview:
Memory-side responder for the L1D cache line-transfer protocol (VALID / ACK_ADDR / ACK_DATA[3:0] / READY).
- Accepts one line request at a time from the cache: LOAD = line fill, STORE = line writeback.
- Waits a programmable access latency, then transfers the 4-word line one word per cycle with a one-hot beat strobe.
- Holds its own word-addressed storage array and sits directly below the L1D cache in the memory subsystem.

Parameters:
ADDR_WIDTH, 32, request byte-address width
MEM_DEPTH_WORDS, 1024, storage size in 32-bit words; must be a multiple of 4
ACCESS_LATENCY, 4, wait cycles between the ACK_ADDR cycle and the first beat; 0 is legal

Ports:
CLK  input  1  clock, all logic on rising edge
RST_N  input  1  synchronous active-low reset
VALID  input  1  cache request valid
LOAD  input  1  request is line read (fill)
STORE  input  1  request is line write (writeback)
ADDR  input  ADDR_WIDTH  request byte address; bits [3:0] select no beat except under the optional feature
WDATA  input  32  store beat data from cache
RDATA  output  32  load beat data
ACK_ADDR  output  1  one-cycle pulse: request accepted
ACK_DATA  output  4  one-hot beat strobe; bit i set = word i of the line transfers this cycle
READY  output  1  idle, can accept a request
ERR  output  1  one-cycle pulse: request rejected

Behaviour:
- Reset: RST_N low at a posedge forces the following output values; they hold while RST_N is low.
  - State IDLE, READY=1.
  - ACK_ADDR=0, ACK_DATA=0, RDATA=0, ERR=0.
  - Storage contents are not cleared by reset.
- All outputs are registered.
- States and transitions: IDLE -> ACK -> WAIT -> BEAT -> IDLE.
  - IDLE: a request is sampled at edge E0 when READY & VALID.
    - Legal request: exactly one of LOAD/STORE set and line index ADDR[ADDR_WIDTH-1:4] < MEM_DEPTH_WORDS/4. It latches the line base (word index = ADDR>>2 with bits [1:0] cleared) and the op.
    - Illegal request: LOAD&STORE both set, neither set, or line index out of range. It is not accepted: ERR=1 for one cycle after E0, READY stays 1, no ACK_ADDR.
  - ACK (cycle 1 after E0): ACK_ADDR=1, READY=0. The latency counter is loaded with ACCESS_LATENCY.
  - WAIT: lasts ACCESS_LATENCY cycles with ACK_DATA=0. When ACCESS_LATENCY=0, BEAT follows ACK directly.
  - BEAT: 4 consecutive cycles, beat k = 0..3, ACK_DATA = 1<<word(k).
    - In-order transfer: word(k) = k.
    - LOAD: RDATA = mem[base+word(k)] in the same cycle as its strobe. RDATA holds its last value outside beats.
    - STORE: the cache drives WDATA for the strobed word while the strobe is high. The word is written at the edge ending that cycle.
  - After beat 3: IDLE with READY=1. A new request can be sampled at the end of that cycle.
- Latency with L = ACCESS_LATENCY:
  - ACK_ADDR in cycle 1.
  - Beats in cycles 2+L .. 5+L.
  - READY=1 in cycle 6+L.
- VALID, LOAD, STORE, ADDR are ignored while READY=0. Deasserting VALID mid-transaction does not abort it.
- Reset mid-transaction: the transaction is abandoned immediately. Store beats already written remain in storage; unwritten words keep their old values.
- A line never crosses the storage boundary, because the base is aligned and the range check is done at accept.

Optional Feature:
MEM_RESP_CRITICAL_WORD_FIRST_EN
- Defined: LOAD beats start at word c = ADDR[3:2] and wrap modulo 4, i.e. word(k) = (c+k) mod 4. ACK_DATA follows the word order, e.g. c=2 gives strobes 0100, 1000, 0001, 0010. STORE stays in order 0..3.
- Undefined: ADDR[3:0] is ignored and all beats are in order.

Test Plan:
1. Hold RST_N=0 for 2 cycles, then release -> READY=1, ACK_ADDR=0, ACK_DATA=0, RDATA=0, ERR=0.
2. L=4, STORE to 0x40 with WDATA A0..A3 -> ACK_ADDR in cycle 1; ACK_DATA 0001/0010/0100/1000 in cycles 6..9; READY=1 in cycle 10.
3. LOAD from 0x48 after test 2:
   - Macro undefined: RDATA A0,A1,A2,A3 with ACK_DATA 0001..1000.
   - Macro defined: RDATA A2,A3,A0,A1 with ACK_DATA 0100,1000,0001,0010.
4. VALID with LOAD=STORE=1, and separately with LOAD=STORE=0 -> ERR=1 for exactly one cycle, no ACK_ADDR, READY stays 1.
5. MEM_DEPTH_WORDS=1024, LOAD from 0x1000 -> ERR pulse, no beats. LOAD from 0xFF0 -> accepted.
6. STORE B0..B3 to 0x40; RST_N=0 during beat 2 -> next cycle READY=1 and ACK_DATA=0; a later LOAD from 0x40 returns B0,B1,A2,A3.

Source files
------------

// File: rtl/main_memory_responder.sv
// Memory-side responder for the L1D line-transfer protocol: accepts one line request,
// waits ACCESS_LATENCY cycles, then moves 4 words with a one-hot beat strobe.
// Optional macro: MEM_RESP_CRITICAL_WORD_FIRST_EN (load beats start at ADDR[3:2] and wrap).
module main_memory_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int ACCESS_LATENCY  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  VALID,
  input  logic                  LOAD,
  input  logic                  STORE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [31:0]           WDATA,
  output logic [31:0]           RDATA,
  output logic                  ACK_ADDR,
  output logic [3:0]            ACK_DATA,
  output logic                  READY,
  output logic                  ERR
);

  localparam int NUM_LINES = MEM_DEPTH_WORDS / 4;
  localparam int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int CNT_W     = (ACCESS_LATENCY > 2) ? $clog2(ACCESS_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-5:0] LINE_LIMIT = (ADDR_WIDTH-4)'(NUM_LINES);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT, S_BEAT} state_t;

  logic [31:0]       mem [MEM_DEPTH_WORDS];
  state_t            state_q;
  logic              load_q;
  logic [LINE_W-1:0] line_q;
  logic [1:0]        start_q;
  logic [1:0]        word_q;
  logic [1:0]        beat_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              legal;
  logic [1:0]        start_word;
  logic [1:0]        next_word;
  logic              begin_beat;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^ADDR[3:0];
  assign legal     = (LOAD ^ STORE) && (ADDR[ADDR_WIDTH-1:4] < LINE_LIMIT);
  assign next_word = word_q + 2'd1;

`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
  assign start_word = LOAD ? ADDR[3:2] : 2'd0;
`else
  assign start_word = 2'd0;
`endif

  // The first beat is launched from either ACK (zero latency) or the last WAIT cycle.
  always_comb begin
    begin_beat = 1'b0;
    if (state_q == S_ACK && ACCESS_LATENCY == 0)
      begin_beat = 1'b1;
    else if (state_q == S_WAIT && cnt_q == '0)
      begin_beat = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      READY    <= 1'b1;
      ACK_ADDR <= 1'b0;
      ACK_DATA <= '0;
      RDATA    <= '0;
      ERR      <= 1'b0;
    end else begin
      ACK_ADDR <= 1'b0;
      ERR      <= 1'b0;
      if (begin_beat) begin
        state_q  <= S_BEAT;
        beat_q   <= 2'd0;
        word_q   <= start_q;
        ACK_DATA <= 4'b0001 << start_q;
        if (load_q)
          RDATA <= mem[{line_q, start_q}];
      end else begin
        case (state_q)
          S_IDLE: begin
            if (VALID) begin
              if (legal) begin
                state_q  <= S_ACK;
                ACK_ADDR <= 1'b1;
                READY    <= 1'b0;
                load_q   <= LOAD;
                line_q   <= ADDR[LINE_W+3:4];
                start_q  <= start_word;
              end else begin
                ERR <= 1'b1;
              end
            end
          end
          S_ACK: begin
            state_q <= S_WAIT;
            cnt_q   <= CNT_W'(ACCESS_LATENCY - 1);
          end
          S_WAIT: cnt_q <= cnt_q - 1'b1;
          S_BEAT: begin
            if (beat_q == 2'd3) begin
              state_q  <= S_IDLE;
              READY    <= 1'b1;
              ACK_DATA <= '0;
            end else begin
              beat_q   <= beat_q + 2'd1;
              word_q   <= next_word;
              ACK_DATA <= 4'b0001 << next_word;
              if (load_q)
                RDATA <= mem[{line_q, next_word}];
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Store beat lands at the edge ending its strobe; a reset on that edge drops it.
  always_ff @(posedge CLK) begin
    if (RST_N && state_q == S_BEAT && !load_q)
      mem[{line_q, word_q}] <= WDATA;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench for main_memory_responder: the stimulus pushes expected ACK/ERR/beat
// events with their absolute cycle; a negedge monitor pops and compares them.
module tb_main_memory_responder;

  localparam int L = 4;
  localparam int K_ACK = 1, K_ERR = 2, K_BEAT = 3;

  logic        CLK = 1'b0;
  logic        RST_N, VALID, LOAD, STORE;
  logic [31:0] ADDR, WDATA;
  logic [31:0] RDATA;
  logic        ACK_ADDR, READY, ERR;
  logic [3:0]  ACK_DATA;

  typedef struct {
    int          kind;
    int          cyc;
    logic [3:0]  strobe;
    logic [31:0] data;
    bit          chk;
  } ev_t;

  ev_t         sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] line_a [4];
  logic [31:0] line_b [4];
  logic [31:0] line_mix [4];

  main_memory_responder #(
    .ADDR_WIDTH(32),
    .MEM_DEPTH_WORDS(1024),
    .ACCESS_LATENCY(L)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .VALID(VALID), .LOAD(LOAD), .STORE(STORE),
    .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .ACK_ADDR(ACK_ADDR),
    .ACK_DATA(ACK_DATA), .READY(READY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int idx(input logic [3:0] s);
    case (s)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic push(input int kind, input int c, input logic [3:0] s,
                      input logic [31:0] d, input bit chk_d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.strobe = s; e.data = d; e.chk = chk_d;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    int  k;
    ev_t e;
    if (RST_N === 1'b1 && (ACK_ADDR === 1'b1 || ERR === 1'b1 || ACK_DATA !== 4'b0000)) begin
      k = (ERR === 1'b1) ? K_ERR : (ACK_ADDR === 1'b1) ? K_ACK : K_BEAT;
      if (sb.size() == 0) begin
        check("unexpected_event_kind", k, 0);
      end else begin
        e = sb.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (k == K_BEAT) check("ack_data", ACK_DATA, e.strobe);
        if (e.chk) check("rdata", RDATA, e.data);
      end
    end
  end

  // Returns x = cyc during cycle 1 after the sampling edge; cycle n has cyc = x+n-1.
  task automatic issue(input logic ld, input logic st, input logic [31:0] a, output int x);
    @(negedge CLK);
    check("ready_before_req", READY, 1);
    #1;
    VALID = 1'b1; LOAD = ld; STORE = st; ADDR = a;
    @(posedge CLK);
    #1;
    x = cyc;
    VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0;
  endtask

  task automatic wait_done(input int x, input bit drive, input logic [31:0] line [4]);
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (drive && ACK_DATA !== 4'b0000) WDATA = line[idx(ACK_DATA)];
      if (READY === 1'b1) begin
        done = 1;
        check("ready_return_cycle", cyc, x + 5 + L);
      end
    end
    if (!done) check("ready_timeout", READY, 1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] line [4], input int abort_k);
    int x;
    bit hit = 0;
    issue(1'b0, 1'b1, a, x);
    push(K_ACK, x, 4'b0000, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++)
      if (abort_k < 0 || k <= abort_k)
        push(K_BEAT, x + 1 + L + k, 4'(4'b0001 << k), 32'h0, 1'b0);
    if (abort_k < 0) begin
      wait_done(x, 1'b1, line);
    end else begin
      for (int i = 0; i < 40; i++) begin
        @(negedge CLK);
        if (ACK_DATA !== 4'b0000) WDATA = line[idx(ACK_DATA)];
        if (ACK_DATA === 4'(4'b0001 << abort_k)) begin
          hit = 1;
          #2 RST_N = 1'b0;
          break;
        end
      end
      check("abort_beat_seen", hit, 1);
      @(negedge CLK);
      check("abort_ready", READY, 1);
      check("abort_ack_data", ACK_DATA, 0);
      check("abort_sb_drained", sb.size(), 0);
      #1 RST_N = 1'b1;
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp_w [4], input bit chk_d);
    int         x;
    logic [1:0] c;
    logic [1:0] w;
    issue(1'b1, 1'b0, a, x);
    push(K_ACK, x, 4'b0000, 32'h0, 1'b0);
`ifdef MEM_RESP_CRITICAL_WORD_FIRST_EN
    c = a[3:2];
`else
    c = 2'd0;
`endif
    for (int k = 0; k < 4; k++) begin
      w = c + 2'(k);
      push(K_BEAT, x + 1 + L + k, 4'(4'b0001 << w), exp_w[w], chk_d);
    end
    wait_done(x, 1'b0, exp_w);
  endtask

  task automatic do_err(input logic ld, input logic st, input logic [31:0] a);
    int x;
    issue(ld, st, a, x);
    push(K_ERR, x, 4'b0000, 32'h0, 1'b0);
    @(negedge CLK);
    check("err_ready_held", READY, 1);
    repeat (3) @(negedge CLK);
    check("err_sb_drained", sb.size(), 0);
    check("err_ready_after", READY, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; VALID = 1'b0; LOAD = 1'b0; STORE = 1'b0; ADDR = '0; WDATA = '0;
    line_a[0] = 32'hA0A0_0000; line_a[1] = 32'hA1A1_1111;
    line_a[2] = 32'hA2A2_2222; line_a[3] = 32'hA3A3_3333;
    line_b[0] = 32'hB0B0_0000; line_b[1] = 32'hB1B1_1111;
    line_b[2] = 32'hB2B2_2222; line_b[3] = 32'hB3B3_3333;
    line_mix[0] = 32'hB0B0_0000; line_mix[1] = 32'hB1B1_1111;
    line_mix[2] = 32'hA2A2_2222; line_mix[3] = 32'hA3A3_3333;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("reset_ready", READY, 1);
    check("reset_ack_addr", ACK_ADDR, 0);
    check("reset_ack_data", ACK_DATA, 0);
    check("reset_rdata", RDATA, 0);
    check("reset_err", ERR, 0);

    do_store(32'h40, line_a, -1);
    do_load(32'h48, line_a, 1'b1);
    do_err(1'b1, 1'b1, 32'h40);
    do_err(1'b0, 1'b0, 32'h40);
    do_err(1'b1, 1'b0, 32'h1000);
    do_load(32'hFF0, line_a, 1'b0);
    do_store(32'h40, line_b, 2);
    do_load(32'h40, line_mix, 1'b1);

    repeat (3) @(negedge CLK);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
